// File: rtl/home_event_annunciator.sv
// Front-panel annunciator: queues controller event codes and shows each on a 7-seg digit.
// Build option ALARM_PREEMPT_EN: a fire alarm (code 3) bypasses the queue and takes over the digit.
//
// state   | meaning
// IDLE    | digit blank, waiting for a queued event
// SHOW    | event on the digit for the hold time or until ack
// GAP     | blank spacer after each event
module home_event_annunciator #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [2:0]             display_i,
    input  logic                   ack_i,
    output logic [6:0]             seg_o,
    output logic [2:0]             evt_code_o,
    output logic                   chime_o,
    output logic [$clog2(DEPTH):0] pending_o,
    output logic                   overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_INIT   = GW'(GAP_CYCLES - 1);
    localparam logic [2:0]    CODE_ALARM = 3'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP} state_t;

    state_t        state_q;
    logic [2:0]    prev_q;
    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [HW-1:0] hold_cnt_q;
    logic [GW-1:0] gap_cnt_q;
    logic [6:0]    seg_q;
    logic [2:0]    evt_code_q;
    logic          chime_q;
    logic          overflow_q;

    logic          is_new, preempt, push_req, fifo_empty, fifo_full;
    logic          pop, push, drop;
    logic [2:0]    head;

    function automatic logic [6:0] seg_pattern(input logic [2:0] code);
        case (code)
            3'd1:    seg_pattern = 7'b0000110;
            3'd2:    seg_pattern = 7'b1011011;
            3'd3:    seg_pattern = 7'b1001111;
            3'd4:    seg_pattern = 7'b1100110;
            3'd5:    seg_pattern = 7'b1101101;
            default: seg_pattern = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        is_new = (display_i >= 3'd1) && (display_i <= 3'd5) && (display_i != prev_q);
`ifdef ALARM_PREEMPT_EN
        preempt = is_new && (display_i == CODE_ALARM);
`else
        preempt = 1'b0;
`endif
        push_req   = is_new && !preempt;
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        // A preempting alarm owns the SHOW transition, so nothing is popped that cycle.
        pop  = !preempt && !fifo_empty &&
               ((state_q == ST_IDLE) || ((state_q == ST_GAP) && (gap_cnt_q == '0)));
        push = push_req && (!fifo_full || pop);
        drop = push_req && !push;
        head = mem_q[rd_ptr_q];
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q  <= display_i;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= display_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            seg_q      <= '0;
            evt_code_q <= '0;
            chime_q    <= 1'b0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            chime_q <= 1'b0;
            if (preempt) begin
                state_q    <= ST_SHOW;
                evt_code_q <= CODE_ALARM;
                seg_q      <= seg_pattern(CODE_ALARM);
                chime_q    <= 1'b1;
                hold_cnt_q <= HOLD_INIT;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (pop) begin
                            state_q    <= ST_SHOW;
                            evt_code_q <= head;
                            seg_q      <= seg_pattern(head);
                            chime_q    <= 1'b1;
                            hold_cnt_q <= HOLD_INIT;
                        end
                    end
                    ST_SHOW: begin
                        if ((hold_cnt_q == '0) || ack_i) begin
                            state_q    <= ST_GAP;
                            seg_q      <= '0;
                            evt_code_q <= '0;
                            gap_cnt_q  <= GAP_INIT;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt_q == '0) begin
                            if (pop) begin
                                state_q    <= ST_SHOW;
                                evt_code_q <= head;
                                seg_q      <= seg_pattern(head);
                                chime_q    <= 1'b1;
                                hold_cnt_q <= HOLD_INIT;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            gap_cnt_q <= gap_cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign seg_o      = seg_q;
    assign evt_code_o = evt_code_q;
    assign chime_o    = chime_q;
    assign pending_o  = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_home_event_annunciator.sv
// Directed bench for home_event_annunciator: vector tables for per-cycle behaviour,
// hand sequences for queueing order, overflow and alarm handling (ALARM_PREEMPT_EN aware).
module tb_home_event_annunciator;
    localparam logic [6:0] P1 = 7'b0000110;
    localparam logic [6:0] P2 = 7'b1011011;
    localparam logic [6:0] P3 = 7'b1001111;
    localparam logic [6:0] P4 = 7'b1100110;

    typedef struct {
        logic       rst;
        logic [2:0] disp;
        logic       ack;
        logic [6:0] seg;
        logic [2:0] code;
        logic       chime;
        int         pend;
        logic       ovf;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [2:0] disp;
    logic       ack;
    logic [6:0] seg;
    logic [2:0] code;
    logic       chime;
    logic [2:0] pend;
    logic       ovf;

    int         n_cmp  = 0;
    int         n_fail = 0;
    vec_t       vecs[$];
    logic [2:0] shown_q[$];

    home_event_annunciator dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .display_i  (disp),
        .ack_i      (ack),
        .seg_o      (seg),
        .evt_code_o (code),
        .chime_o    (chime),
        .pending_o  (pend),
        .overflow_o (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] d, input logic a);
        rst  = r;
        disp = d;
        ack  = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (chime) shown_q.push_back(code);
    endtask

    task automatic add(input logic r, input logic [2:0] d, input logic a, input logic [6:0] s,
                       input logic [2:0] c, input logic ch, input int p, input logic o);
        vec_t v;
        v.rst = r; v.disp = d; v.ack = a; v.seg = s; v.code = c; v.chime = ch; v.pend = p; v.ovf = o;
        vecs.push_back(v);
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].disp, vecs[i].ack);
            tick();
            chk($sformatf("%s[%0d].seg", tag, i),      int'(seg),   int'(vecs[i].seg));
            chk($sformatf("%s[%0d].code", tag, i),     int'(code),  int'(vecs[i].code));
            chk($sformatf("%s[%0d].chime", tag, i),    int'(chime), int'(vecs[i].chime));
            chk($sformatf("%s[%0d].pending", tag, i),  int'(pend),  vecs[i].pend);
            chk($sformatf("%s[%0d].overflow", tag, i), int'(ovf),   int'(vecs[i].ovf));
        end
        vecs.delete();
    endtask

    task automatic wait_shown(input int n, input int budget, input string tag);
        for (int b = 0; b < budget && shown_q.size() < n; b++) tick();
        chk($sformatf("%s.shown_count", tag), shown_q.size(), n);
    endtask

    initial begin
        int exp_pend3[5];
        int disp3[5];
        int exp_order3[5];
        int disp4[6];
        int exp_pend4[6];
        int exp_ovf4[6];
        int exp_order6[4];
        int peak;

        drive(1'b1, 3'd3, 1'b0);

        // reset with alarm on the bus, detection after release, reset mid-SHOW
        add(1, 3, 0, 0, 0, 0, 0, 0);
        add(1, 3, 0, 0, 0, 0, 0, 0);
`ifdef ALARM_PREEMPT_EN
        add(0, 3, 0, P3, 3, 1, 0, 0);
        add(0, 0, 0, P3, 3, 0, 0, 0);
`else
        add(0, 3, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, P3, 3, 1, 0, 0);
`endif
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        run_vecs("reset");

        // single event: 2-cycle latency, 8 shown, 2 blank, back to idle
        add(0, 1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, P1, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 0, 0, P1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 0, 0);
        run_vecs("single");

        // ack in 3rd SHOW cycle, ack ignored in GAP, ack in 1st SHOW cycle
        add(0, 2, 0, 0, 0, 0, 1, 0);
        add(0, 4, 0, P2, 2, 1, 1, 0);
        add(0, 0, 0, P2, 2, 0, 1, 0);
        add(0, 0, 0, P2, 2, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, P4, 4, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        run_vecs("ack");

        // back-to-back codes 1,2,4,5,1: first pops at once, the rest fill the FIFO
        shown_q.delete();
        disp3      = '{1, 2, 4, 5, 1};
        exp_pend3  = '{1, 1, 2, 3, 4};
        exp_order3 = '{1, 2, 4, 5, 1};
        peak = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 3'(disp3[i]), 1'b0);
            tick();
            chk($sformatf("burst.pending[%0d]", i), int'(pend), exp_pend3[i]);
            if (int'(pend) > peak) peak = int'(pend);
        end
        drive(1'b0, 3'd0, 1'b0);
        chk("burst.peak", peak, 4);
        wait_shown(5, 100, "burst");
        for (int i = 0; i < 5; i++)
            if (i < shown_q.size()) chk($sformatf("burst.order[%0d]", i), int'(shown_q[i]), exp_order3[i]);
        chk("burst.overflow", int'(ovf), 0);

        // overflow: six events while SHOW is busy, DEPTH 4
        drive(1'b1, 3'd0, 1'b0);
        tick();
        drive(1'b0, 3'd1, 1'b0);
        tick();
        drive(1'b0, 3'd0, 1'b0);
        tick();
        chk("ovf.show_seg", int'(seg), int'(P1));
        chk("ovf.show_pending", int'(pend), 0);
        disp4     = '{2, 4, 5, 1, 2, 4};
        exp_pend4 = '{1, 2, 3, 4, 4, 4};
        exp_ovf4  = '{0, 0, 0, 0, 1, 1};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 3'(disp4[i]), 1'b0);
            tick();
            chk($sformatf("ovf.pending[%0d]", i), int'(pend), exp_pend4[i]);
            chk($sformatf("ovf.flag[%0d]", i), int'(ovf), exp_ovf4[i]);
        end
        drive(1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 60; i++) tick();
        chk("ovf.sticky", int'(ovf), 1);
        chk("ovf.drained", int'(pend), 0);
        drive(1'b1, 3'd0, 1'b0);
        tick();
        chk("ovf.cleared", int'(ovf), 0);
        drive(1'b0, 3'd0, 1'b0);
        tick();

        // alarm arriving mid-SHOW of code 4 with two events queued
        shown_q.delete();
        drive(1'b0, 3'd4, 1'b0);
        tick();
        drive(1'b0, 3'd0, 1'b0);
        tick();
        drive(1'b0, 3'd1, 1'b0);
        tick();
        drive(1'b0, 3'd2, 1'b0);
        tick();
        chk("alarm.pending_before", int'(pend), 2);
        drive(1'b0, 3'd3, 1'b0);
        tick();
`ifdef ALARM_PREEMPT_EN
        chk("alarm.seg", int'(seg), int'(P3));
        chk("alarm.chime", int'(chime), 1);
        chk("alarm.pending", int'(pend), 2);
        exp_order6 = '{4, 3, 1, 2};
`else
        chk("alarm.seg", int'(seg), int'(P4));
        chk("alarm.chime", int'(chime), 0);
        chk("alarm.pending", int'(pend), 3);
        exp_order6 = '{4, 1, 2, 3};
`endif
        drive(1'b0, 3'd0, 1'b0);
        wait_shown(4, 120, "alarm");
        for (int i = 0; i < 4; i++)
            if (i < shown_q.size()) chk($sformatf("alarm.order[%0d]", i), int'(shown_q[i]), exp_order6[i]);
        for (int i = 0; i < 30; i++) tick();
        chk("alarm.no_repeat", shown_q.size(), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
